// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and sizes for the hazard/forwarding controller.
package hazard_scoreboard_pkg;

   // EX-stage operand source selects.
   typedef enum logic [1:0] {
      FWD_RF   = 2'd0,
      FWD_MEM  = 2'd1,
      FWD_WB   = 2'd2,
      FWD_RSVD = 2'd3
   } fwdSel_e;

   localparam int FWD_W      = 2;
   // In-flight entries: E0 (EX), E1 (MEM), E2 (WB).
   localparam int SB_ENTRIES = 3;
   // Per-entry flag bits: valid, reg_write, is_load.
   localparam int SB_FLAG_W  = 3;
   // Squash counter must hold FLUSH_SLOTS up to 7.
   localparam int SQ_CNT_W   = 3;

   // Stages whose load data is not yet available for forwarding.
   // Only a load sitting in EX forces a stall; from MEM on it forwards.
   localparam logic [SB_ENTRIES-1:0] LOAD_USE_STAGES = 3'b001;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and hazard-control response bundle.
interface hazard_scoreboard_if #(
   parameter int REG_AW = 3,
   parameter int NUM_RD = 2,
   parameter int CNT_W  = 16
);
   logic                     id_valid;
   logic [REG_AW-1:0]        id_dest;
   logic                     id_reg_write;
   logic                     id_is_load;
   logic [NUM_RD*REG_AW-1:0] id_src_addr;
   logic [NUM_RD-1:0]        id_src_used;
   logic                     flush_id;
   logic                     stall;
   logic                     idex_bubble;
   logic [NUM_RD*2-1:0]      ex_fwd_sel;
   logic [CNT_W-1:0]         stall_cnt;
   logic [CNT_W-1:0]         flush_cnt;

   // Pipeline side: presents the ID instruction, consumes hazard controls.
   modport master (
      output id_valid, id_dest, id_reg_write, id_is_load, id_src_addr, id_src_used, flush_id,
      input  stall, idex_bubble, ex_fwd_sel, stall_cnt, flush_cnt
   );

   // Controller side.
   modport slave (
      input  id_valid, id_dest, id_reg_write, id_is_load, id_src_addr, id_src_used, flush_id,
      output stall, idex_bubble, ex_fwd_sel, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: remembers a single in-flight destination and its flags.
module hazard_sb_entry #(
   parameter int REG_AW = 3
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              validIn,
   input  logic [REG_AW-1:0] destIn,
   input  logic              regWriteIn,
   input  logic              isLoadIn,
   output logic              validQ,
   output logic [REG_AW-1:0] destQ,
   output logic              regWriteQ,
   output logic              isLoadQ
);

   // Capture the upstream slot every cycle; reset drops the tracking at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         validQ    <= 1'b0;
         destQ     <= '0;
         regWriteQ <= 1'b0;
         isLoadQ   <= 1'b0;
      end else begin
         validQ    <= validIn;
         destQ     <= destIn;
         regWriteQ <= regWriteIn;
         isLoadQ   <= isLoadIn;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the five-stage in-order pipeline.
// Tracks EX/MEM/WB destinations, stalls on load-use, squashes wrong-path
// slots after a control transfer and registers per-source forwarding selects.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_AW      = 3,
   parameter int NUM_RD      = 2,
   parameter int FLUSH_SLOTS = 1,
   parameter int ZERO_REG    = 1,
   parameter int CNT_W       = 16
)(
   input logic                clk,
   input logic                rst,
   hazard_scoreboard_if.slave hz
);

   logic [SB_ENTRIES-1:0]   entValid, entRegWrite, entIsLoad;
   logic [REG_AW-1:0]       entDest [SB_ENTRIES];
   logic [SB_ENTRIES-1:0]   inValid, inRegWrite, inIsLoad;
   logic [REG_AW-1:0]       inDest [SB_ENTRIES];
   logic [NUM_RD-1:0]       portLoadUse;
   logic [NUM_RD*FWD_W-1:0] fwdSelNext, fwdSelReg;
   logic [SQ_CNT_W-1:0]     sqCntReg;
   logic [CNT_W-1:0]        stallCntReg, flushCntReg;
   logic                    squash, stall, idexBubble;

   // Scoreboard shift chain: ID feeds E0 (as a bubble when held or squashed),
   // each later entry copies its predecessor. It never freezes.
   for (genvar gi = 0; gi < SB_ENTRIES; gi++) begin : gStage
      if (gi == 0) begin : gHead
         assign inValid[gi]    = hz.id_valid & ~idexBubble;
         assign inDest[gi]     = hz.id_dest;
         assign inRegWrite[gi] = hz.id_reg_write;
         assign inIsLoad[gi]   = hz.id_is_load;
      end else begin : gChain
         assign inValid[gi]    = entValid[gi-1];
         assign inDest[gi]     = entDest[gi-1];
         assign inRegWrite[gi] = entRegWrite[gi-1];
         assign inIsLoad[gi]   = entIsLoad[gi-1];
      end

      hazard_sb_entry #(.REG_AW(REG_AW)) uEntry (
         .clk        (clk),
         .rst        (rst),
         .validIn    (inValid[gi]),
         .destIn     (inDest[gi]),
         .regWriteIn (inRegWrite[gi]),
         .isLoadIn   (inIsLoad[gi]),
         .validQ     (entValid[gi]),
         .destQ      (entDest[gi]),
         .regWriteQ  (entRegWrite[gi]),
         .isLoadQ    (entIsLoad[gi])
      );
   end

   // Per-source dependency check and forwarding priority.
   for (genvar gi = 0; gi < NUM_RD; gi++) begin : gPort
      logic [REG_AW-1:0]     srcAddr;
      logic                  srcLive;
      logic [SB_ENTRIES-1:0] hitVec;
      fwdSel_e               portSel;

      assign srcAddr = hz.id_src_addr[gi*REG_AW +: REG_AW];
      // A hardwired-zero source never depends on anything in flight.
      assign srcLive = hz.id_valid & hz.id_src_used[gi]
                     & ~((ZERO_REG != 0) && (srcAddr == '0));

      // Compare this source against every in-flight destination.
      always_comb begin
         hitVec = '0;
         for (int s = 0; s < SB_ENTRIES; s++) begin
            hitVec[s] = srcLive & entValid[s] & entRegWrite[s] & (entDest[s] == srcAddr);
         end
      end

      assign portLoadUse[gi] = |(hitVec & entIsLoad & LOAD_USE_STAGES);

      // Nearest producer wins; an E2-only hit reads the RF, which is write-before-read.
      always_comb begin
         portSel = FWD_RF;
         casez (hitVec)
            3'b??1:  portSel = FWD_MEM;
            3'b?10:  portSel = FWD_WB;
            default: portSel = FWD_RF;
         endcase
      end

      assign fwdSelNext[gi*FWD_W +: FWD_W] = portSel;
   end

   // Squash overrides the load-use stall: the held instruction is wrong-path anyway.
   assign squash     = hz.flush_id | (sqCntReg != '0);
   assign stall      = (|portLoadUse) & ~squash;
   assign idexBubble = stall | squash;

   assign hz.stall       = stall;
   assign hz.idex_bubble = idexBubble;
   assign hz.ex_fwd_sel  = fwdSelReg;
   assign hz.stall_cnt   = stallCntReg;
   assign hz.flush_cnt   = flushCntReg;

   // Squash window: (re)load on flush_id, then count down to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sqCntReg <= '0;
      end else if (hz.flush_id) begin
         sqCntReg <= SQ_CNT_W'(FLUSH_SLOTS);
      end else if (sqCntReg != '0) begin
         sqCntReg <= sqCntReg - SQ_CNT_W'(1);
      end
   end

   // Forwarding selects travel with the instruction into EX; bubbles read the RF.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fwdSelReg <= '0;
      end else if (idexBubble) begin
         fwdSelReg <= '0;
      end else begin
         fwdSelReg <= fwdSelNext;
      end
   end

   // Saturating stall and squash counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallCntReg <= '0;
         flushCntReg <= '0;
      end else begin
         if (stall && (stallCntReg != '1)) begin
            stallCntReg <= stallCntReg + CNT_W'(1);
         end
         if (squash && (flushCntReg != '1)) begin
            flushCntReg <= flushCntReg + CNT_W'(1);
         end
      end
   end

endmodule
